pc_controller: RTL

Upstream neighbour of the instruction fetcher. It generates the fetch PC stream and keeps one PC outstanding at a time. For each issued PC it waits for the fetched instruction word and predicts the next PC from it: JAL is taken, conditional branches use a 2-bit BHT, everything else falls through to PC+4. It then pushes the next PC together with the taken/not-taken flag for the previous PC. It also takes redirects on flush and BHT training from commit.

---
 rtl/pc_controller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pc_controller.sv
`default_nettype none
// ============================================================================
// Module   : pc_controller
// Purpose  : Issues one fetch PC at a time. Predicts the next PC from the
//            returned instruction word, using a 2-bit BHT for branches.
// Revision : 1.0
// ============================================================================
module pc_controller #(
    parameter int                ADDR_W   = 32,
    parameter int                BHT_BITS = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_rdy,
    input  logic              in_fetch_full,
    output logic              out_fetcher_enable,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_predict,
    input  logic              in_last_enable,
    input  logic [31:0]       in_last_inst,
    input  logic              in_flush_enable,
    input  logic [ADDR_W-1:0] in_flush_pc,
    input  logic              in_bht_update_enable,
    input  logic [ADDR_W-1:0] in_bht_update_pc,
    input  logic              in_bht_update_taken
);

    localparam int         BHT_DEPTH    = 1 << BHT_BITS;
    localparam logic [6:0] c_op_jal     = 7'b1101111;
    localparam logic [6:0] c_op_branch  = 7'b1100011;

    typedef enum logic [0:0] {
        ST_ISSUE = 1'b0,
        ST_WAIT  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pred_q, pred_d;
    logic [ADDR_W-1:0] cur_pc_q, cur_pc_d;
    logic              fen_q, fen_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              out_pred_q, out_pred_d;

    logic [1:0]        bht_q [BHT_DEPTH];

    logic [6:0]          opcode;
    logic [ADDR_W-1:0]   j_imm;
    logic [ADDR_W-1:0]   b_imm;
    logic [BHT_BITS-1:0] lookup_idx;
    logic [1:0]          lookup_ctr;

    logic                bht_we;
    logic [BHT_BITS-1:0] upd_idx;
    logic [1:0]          upd_old;
    logic [1:0]          upd_new;

    logic unused_upd_bits;

    assign opcode     = in_last_inst[6:0];
    assign j_imm      = {{(ADDR_W-20){in_last_inst[31]}}, in_last_inst[19:12],
                         in_last_inst[20], in_last_inst[30:21], 1'b0};
    assign b_imm      = {{(ADDR_W-12){in_last_inst[31]}}, in_last_inst[7],
                         in_last_inst[30:25], in_last_inst[11:8], 1'b0};
    assign lookup_idx = cur_pc_q[BHT_BITS+1:2];
    assign lookup_ctr = bht_q[lookup_idx];

    // Lookup reads bht_q directly, so a same-cycle update is not yet visible.
    assign upd_idx = in_bht_update_pc[BHT_BITS+1:2];
    assign upd_old = bht_q[upd_idx];
    assign bht_we  = in_rdy && in_bht_update_enable;

    assign unused_upd_bits = ^{in_bht_update_pc[ADDR_W-1:BHT_BITS+2],
                               in_bht_update_pc[1:0]};

    always_comb begin
        upd_new = upd_old;
        if (in_bht_update_taken) begin
            if (upd_old != 2'b11) upd_new = upd_old + 2'b01;
        end else begin
            if (upd_old != 2'b00) upd_new = upd_old - 2'b01;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pred_d     = pred_q;
        cur_pc_d   = cur_pc_q;
        fen_d      = 1'b0;
        out_pc_d   = out_pc_q;
        out_pred_d = out_pred_q;

        if (in_rdy) begin
            if (in_flush_enable) begin
                pc_d    = in_flush_pc;
                pred_d  = 1'b0;
                state_d = ST_ISSUE;
            end else begin
                case (state_q)
                    ST_ISSUE: begin
                        if (!in_fetch_full) begin
                            fen_d      = 1'b1;
                            out_pc_d   = pc_q;
                            out_pred_d = pred_q;
                            cur_pc_d   = pc_q;
                            state_d    = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (in_last_enable) begin
                            state_d = ST_ISSUE;
                            if (opcode == c_op_jal) begin
                                pc_d   = cur_pc_q + j_imm;
                                pred_d = 1'b1;
                            end else if (opcode == c_op_branch && lookup_ctr[1]) begin
                                pc_d   = cur_pc_q + b_imm;
                                pred_d = 1'b1;
                            end else begin
                                pc_d   = cur_pc_q + ADDR_W'(4);
                                pred_d = 1'b0;
                            end
                        end
                    end
                    default: state_d = ST_ISSUE;
                endcase
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= ST_ISSUE;
            pc_q       <= RESET_PC;
            pred_q     <= 1'b0;
            cur_pc_q   <= '0;
            fen_q      <= 1'b0;
            out_pc_q   <= '0;
            out_pred_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_q     <= pred_d;
            cur_pc_q   <= cur_pc_d;
            fen_q      <= fen_d;
            out_pc_q   <= out_pc_d;
            out_pred_q <= out_pred_d;
        end
    end

    // Counters come out of reset weakly not-taken.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_we) begin
            bht_q[upd_idx] <= upd_new;
        end
    end

    assign out_fetcher_enable = fen_q;
    assign out_pc             = out_pc_q;
    assign out_predict        = out_pred_q;

endmodule
`default_nettype wire
